pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Central stall/flush controller for the five-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It resolves data-cache waits, load-use hazards, taken branches and instruction-fetch misses. It also sequences processor halt: it drains the pipeline, requests a data-cache writeback flush, and asserts a sticky halt to the system.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`regbits_t` = 5 bits).
- CLK  in  1  system clock, rising edge
- nRST  in  1  reset, synchronous, active-low
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mm_dREN, mm_dWEN  in  1 each  EX/MEM latch holds a load/store
- mm_halt  in  1  EX/MEM latch holds a halt
- wb_halt  in  1  MEM/WB latch holds a halt (wb-side halt)
- ex_MemRead  in  1  ID/EX latch holds a load
- ex_rd  in  5  ID/EX destination register
- id_rs, id_rt  in  5 each  IF/ID source registers
- ex_branch_taken  in  1  branch/jump redirect resolved in EX
- dflush_done  in  1  data cache finished writeback flush
- pc_en, ifid_en, idex_en, exmm_en, mmwb_en  out  1 each  latch/PC enables
- ifid_flush, idex_flush, exmm_flush, mmwb_flush  out  1 each  load a bubble on the next enabled edge
- dflush_req  out  1  request data cache flush
- halt  out  1  sticky processor halt

## Operation
FSM states: RUN, MEMWAIT, DRAIN, DFLUSH, HALTED. Reset state is RUN.

**RUN, priority high to low:**
1. **Memory miss:** `(mm_dREN|mm_dWEN) & !dhit`.
   - pc, IF/ID, ID/EX and EX/MEM enables are 0.
   - `mmwb_en=1` with `mmwb_flush=1`.
   - Next state is MEMWAIT.
2. **Halt in MEM:** `mm_halt`.
   - `pc_en=0`.
   - `ifid_flush=idex_flush=1`, with all enables 1 so the halt advances.
   - EX/MEM is not flushed.
3. **Taken branch:** `ex_branch_taken`.
   - `ifid_flush=idex_flush=1`; all enables 1.
4. **Load-use:** `ex_MemRead & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt)`.
   - `pc_en=ifid_en=0`; `idex_flush=1`.
   - EX/MEM and MEM/WB advance.
5. **Fetch miss:** `!ihit`.
   - `pc_en=0`; `ifid_flush=1`.
   - All other stages advance.
6. **Otherwise:** all enables 1, all flushes 0.

**wb_halt:** when `wb_halt` is high, the MEM/WB write completes this cycle and the next state is DRAIN. This takes precedence over rules 1–6.

**MEMWAIT:**
- Holds the same outputs as rule 1 until `dhit`.
- On the `dhit` cycle, the RUN rules 2–6 apply with the miss condition masked; next state is RUN.

**DRAIN:**
- All enables 0.
- Next state is DFLUSH.

**DFLUSH:**
- All enables 0; `dflush_req=1`.
- On `dflush_done`, next state is HALTED.

**HALTED:**
- All enables 0; `halt=1`.
- Leaves only on reset.

**Shared rules:**
- Flushes are only meaningful when the matching enable is 1. The block never asserts a flush with its enable 0.

## Timing
- All latch-control outputs are combinational from state and inputs; they act on the same rising edge.
- `halt` and `dflush_req` are decoded from registered state: glitch-free, one cycle after the transition condition.
- **Halt latency:** `wb_halt` high at edge N, DRAIN during cycle N+1, `dflush_req` from N+2, `halt` one cycle after the `dflush_done` edge.
- **Reset:** every output 0 while `nRST=0` at an edge, except enables, which are 1 so latches clear through their own reset. State returns to RUN.
- **Reset during DFLUSH:** drops `dflush_req` on the next edge.
- **Simultaneous miss and branch:** the branch flush is deferred until the `dhit` cycle. `ex_branch_taken` is held stable by the stalled ID/EX latch.
- **`dhit` with `wb_halt`:** DRAIN wins.

## Configuration
- `PIPELINE_PERF_EN` defined:
  - Adds outputs `stall_cycles` (32) and `flush_events` (32).
  - `stall_cycles` counts cycles with `pc_en=0` in RUN/MEMWAIT.
  - `flush_events` counts cycles with any flush asserted.
  - Both wrap modulo 2^32, reset to 0, and freeze in DRAIN/DFLUSH/HALTED.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

## Structure
- Add `seq_state_t` (enum logic[2:0]: RUN, MEMWAIT, DRAIN, DFLUSH, HALTED) to `control_unit_types_pkg`.
- Add an optional `pipe_ctrl_t` struct (en, flush) for the stage controls.
- One sub-module: `hazard_detect`, a combinational load-use/branch evaluator that returns per-stage en/flush for RUN. The FSM wraps it.

## Test plan
- Load-use: `ex_MemRead=1`, `ex_rd=5`, `id_rs=5`, `ihit=1` → `pc_en=0`, `ifid_en=0`, `idex_flush=1`, `exmm_en=1`. With `ex_rd=0` → no stall.
- Data miss: `mm_dREN=1`, `dhit=0` for 3 cycles then 1 → 3 cycles with `pc_en=ifid_en=idex_en=exmm_en=0` and `mmwb_flush=1`, then all enables 1 on the `dhit` cycle.
- Branch plus fetch miss: `ex_branch_taken=1`, `ihit=0` → `ifid_flush=idex_flush=1`, `pc_en=1`.
- Halt sequence: `mm_halt` for 1 cycle, then `wb_halt`, then `dflush_done` 4 cycles later → younger stages flushed, DRAIN, `dflush_req` high 4 cycles, then `halt=1` held for 10+ cycles.
- Reset mid-DFLUSH: `nRST=0` while `dflush_req=1` → `dflush_req=0` and `halt=0` after the edge, state RUN.
- `PIPELINE_PERF_EN`: 3-cycle miss plus 1 load-use stall → `stall_cycles=4`. Preload counter to 0xFFFFFFFF → wraps to 0.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_sequencer_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    MEMWAIT = 3'd1,
    DRAIN   = 3'd2,
    DFLUSH  = 3'd3,
    HALTED  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } pipe_ctrl_t;

  // Latch index order used by the en/flush vectors.
  localparam int LATCH_IFID = 0;
  localparam int LATCH_IDEX = 1;
  localparam int LATCH_EXMM = 2;
  localparam int LATCH_MMWB = 3;

  function automatic logic reg_hazard(regbits_t rd, regbits_t rs, regbits_t rt);
    return (rd != '0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Combinational RUN-state evaluator: halt-in-MEM, taken branch, load-use and fetch miss.
// Zero latency; a stall holds the PC and older-facing latches and injects one bubble downstream.
module hazard_detect
  import pipeline_sequencer_pkg::*;
(
  input  logic       mm_halt,
  input  logic       ex_branch_taken,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ihit,
  output logic       pc_en,
  output logic [3:0] en,
  output logic [3:0] flush
);

  always_comb begin
    pc_en = 1'b1;
    en    = 4'b1111;
    flush = 4'b0000;
    if (mm_halt) begin
      // Halt keeps moving toward WB; kill the younger instructions behind it.
      pc_en             = 1'b0;
      flush[LATCH_IFID] = 1'b1;
      flush[LATCH_IDEX] = 1'b1;
    end else if (ex_branch_taken) begin
      flush[LATCH_IFID] = 1'b1;
      flush[LATCH_IDEX] = 1'b1;
    end else if (ex_MemRead && reg_hazard(ex_rd, id_rs, id_rt)) begin
      pc_en             = 1'b0;
      en[LATCH_IFID]    = 1'b0;
      flush[LATCH_IDEX] = 1'b1;
    end else if (!ihit) begin
      pc_en             = 1'b0;
      flush[LATCH_IFID] = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush controller and halt sequencer for the five-stage pipeline.
// Optional PIPELINE_PERF_EN adds stall_cycles / flush_events counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       mm_dREN,
  input  logic       mm_dWEN,
  input  logic       mm_halt,
  input  logic       wb_halt,
  input  logic       ex_MemRead,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_branch_taken,
  input  logic       dflush_done,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmm_en,
  output logic       mmwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmm_flush,
  output logic       mmwb_flush,
  output logic       dflush_req,
  output logic       halt
`ifdef PIPELINE_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  seq_state_t       state, state_nxt;
  pipe_ctrl_t [3:0] ctrl;
  logic             pc_ctrl;
  logic             hz_pc_en;
  logic [3:0]       hz_en, hz_flush;
  logic             mem_miss;

  hazard_detect u_hazard (
    .mm_halt         (mm_halt),
    .ex_branch_taken (ex_branch_taken),
    .ex_MemRead      (ex_MemRead),
    .ex_rd           (ex_rd),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ihit            (ihit),
    .pc_en           (hz_pc_en),
    .en              (hz_en),
    .flush           (hz_flush)
  );

  assign mem_miss = (mm_dREN | mm_dWEN) & ~dhit;

  always_comb begin
    state_nxt = state;
    pc_ctrl   = 1'b0;
    ctrl      = '0;
    unique case (state)
      RUN, MEMWAIT: begin
        if (wb_halt) begin
          // Whole pipe freezes; the halt's WB write retires on this edge.
          state_nxt = DRAIN;
        end else if ((state == RUN && mem_miss) || (state == MEMWAIT && !dhit)) begin
          ctrl[LATCH_MMWB].en    = 1'b1;
          ctrl[LATCH_MMWB].flush = 1'b1;
          state_nxt              = MEMWAIT;
        end else begin
          pc_ctrl = hz_pc_en;
          for (int i = 0; i < 4; i++) begin
            ctrl[i].en    = hz_en[i];
            ctrl[i].flush = hz_flush[i];
          end
          state_nxt = RUN;
        end
      end
      DRAIN:   state_nxt = DFLUSH;
      DFLUSH:  if (dflush_done) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
    // Under reset latches stay enabled so they clear through their own reset.
    if (!nRST) begin
      state_nxt = RUN;
      pc_ctrl   = 1'b1;
      for (int i = 0; i < 4; i++) begin
        ctrl[i].en    = 1'b1;
        ctrl[i].flush = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  assign pc_en      = pc_ctrl;
  assign ifid_en    = ctrl[LATCH_IFID].en;
  assign idex_en    = ctrl[LATCH_IDEX].en;
  assign exmm_en    = ctrl[LATCH_EXMM].en;
  assign mmwb_en    = ctrl[LATCH_MMWB].en;
  assign ifid_flush = ctrl[LATCH_IFID].flush;
  assign idex_flush = ctrl[LATCH_IDEX].flush;
  assign exmm_flush = ctrl[LATCH_EXMM].flush;
  assign mmwb_flush = ctrl[LATCH_MMWB].flush;
  assign dflush_req = (state == DFLUSH);
  assign halt       = (state == HALTED);

`ifdef PIPELINE_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (state == RUN || state == MEMWAIT) begin
      if (!pc_ctrl)
        stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush | idex_flush | exmm_flush | mmwb_flush)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized and directed bench for pipeline_sequencer against a stall-depth reference model.
module tb_pipeline_sequencer;

  logic       CLK = 1'b0;
  logic       nRST, ihit, dhit, mm_dREN, mm_dWEN, mm_halt, wb_halt;
  logic       ex_MemRead, ex_branch_taken, dflush_done;
  logic [4:0] ex_rd, id_rs, id_rt;
  logic       pc_en, ifid_en, idex_en, exmm_en, mmwb_en;
  logic       ifid_flush, idex_flush, exmm_flush, mmwb_flush, dflush_req, halt;
`ifdef PIPELINE_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int vectors     = 0;
  int miscompares = 0;

  localparam int M_RUN = 0, M_MEMWAIT = 1, M_DRAIN = 2, M_DFLUSH = 3, M_HALTED = 4;
  int          mmode = M_RUN;
  logic [31:0] exp_stall = 0, exp_flush = 0;

  // {pc, ifid_en, idex_en, exmm_en, mmwb_en, ifid_f, idex_f, exmm_f, mmwb_f, dflush_req, halt}
  logic [10:0] obs;
  assign obs = {pc_en, ifid_en, idex_en, exmm_en, mmwb_en,
                ifid_flush, idex_flush, exmm_flush, mmwb_flush, dflush_req, halt};

  localparam logic [10:0] ALL_RUN  = 11'b11111_0000_00;
  localparam logic [10:0] MISS     = 11'b00001_0001_00;
  localparam logic [10:0] LOADUSE  = 11'b00111_0100_00;
  localparam logic [10:0] BRANCH   = 11'b11111_1100_00;
  localparam logic [10:0] HALT_MEM = 11'b01111_1100_00;
  localparam logic [10:0] FETCH    = 11'b01111_1000_00;
  localparam logic [10:0] FROZEN   = 11'b00000_0000_00;
  localparam logic [10:0] FLUSHING = 11'b00000_0000_10;
  localparam logic [10:0] HALTED_O = 11'b00000_0000_01;

  pipeline_sequencer dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mm_dREN(mm_dREN), .mm_dWEN(mm_dWEN), .mm_halt(mm_halt), .wb_halt(wb_halt),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
    .ex_branch_taken(ex_branch_taken), .dflush_done(dflush_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmm_en(exmm_en), .mmwb_en(mmwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmm_flush(exmm_flush),
    .mmwb_flush(mmwb_flush), .dflush_req(dflush_req), .halt(halt)
`ifdef PIPELINE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 CLK = ~CLK;

  // Model: a stall of depth k holds the PC and the first k-1 latches; the first
  // still-enabled latch may receive a bubble; branch/halt also kill IF/ID and ID/EX.
  function automatic logic [10:0] model_out();
    int         k = 0;
    logic       bubble = 1'b0, kill = 1'b0;
    logic [4:0] en;
    logic [4:1] fl;
    if (!nRST) begin
      k = 0;
    end else if (mmode >= M_DRAIN || wb_halt) begin
      k = 5;
    end else if ((mmode == M_RUN && (mm_dREN || mm_dWEN) && !dhit) ||
                 (mmode == M_MEMWAIT && !dhit)) begin
      k = 4; bubble = 1'b1;
    end else if (mm_halt) begin
      k = 1; bubble = 1'b1; kill = 1'b1;
    end else if (ex_branch_taken) begin
      kill = 1'b1;
    end else if (ex_MemRead && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt)) begin
      k = 2; bubble = 1'b1;
    end else if (!ihit) begin
      k = 1; bubble = 1'b1;
    end
    for (int i = 0; i < 5; i++) en[i] = (i >= k);
    for (int j = 1; j < 5; j++) fl[j] = (bubble && j == k) || (kill && j <= 2);
    return {en[0], en[1], en[2], en[3], en[4], fl[1], fl[2], fl[3], fl[4],
            mmode == M_DFLUSH, mmode == M_HALTED};
  endfunction

  task automatic tick();
    logic [10:0] e;
    int          nxt;
    e = model_out();
    if (!nRST) begin
      exp_stall = 0; exp_flush = 0;
    end else if (mmode <= M_MEMWAIT) begin
      if (!e[10])     exp_stall = exp_stall + 1;
      if (|e[5:2])    exp_flush = exp_flush + 1;
    end
    nxt = mmode;
    if (!nRST)                                          nxt = M_RUN;
    else if (mmode <= M_MEMWAIT && wb_halt)             nxt = M_DRAIN;
    else if (mmode == M_RUN)                            nxt = ((mm_dREN || mm_dWEN) && !dhit) ? M_MEMWAIT : M_RUN;
    else if (mmode == M_MEMWAIT)                        nxt = dhit ? M_RUN : M_MEMWAIT;
    else if (mmode == M_DRAIN)                          nxt = M_DFLUSH;
    else if (mmode == M_DFLUSH && dflush_done)          nxt = M_HALTED;
    @(posedge CLK);
    mmode = nxt;
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b1; mm_dREN = 1'b0; mm_dWEN = 1'b0;
    mm_halt = 1'b0; wb_halt = 1'b0; ex_MemRead = 1'b0; ex_branch_taken = 1'b0;
    dflush_done = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    tick();
    #1;
    vectors++;
    if (obs !== ALL_RUN) begin
      $display("FAIL reset_outputs got=%b want=%b", obs, ALL_RUN); miscompares++;
    end
`ifdef PIPELINE_PERF_EN
    vectors++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cycles, flush_events); miscompares++;
    end
`endif
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    #1; vectors++;
    if (obs !== LOADUSE) begin $display("FAIL load_use_rs got=%b want=%b", obs, LOADUSE); miscompares++; end
    tick();
    id_rs = 5'd1; id_rt = 5'd5;
    #1; vectors++;
    if (obs !== LOADUSE) begin $display("FAIL load_use_rt got=%b want=%b", obs, LOADUSE); miscompares++; end
    tick();
    ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1; vectors++;
    if (obs !== ALL_RUN) begin $display("FAIL load_use_rd0 got=%b want=%b", obs, ALL_RUN); miscompares++; end
    tick();
    ex_MemRead = 1'b0; ex_rd = 5'd5; id_rs = 5'd5;
    #1; vectors++;
    if (obs !== ALL_RUN) begin $display("FAIL no_memread got=%b want=%b", obs, ALL_RUN); miscompares++; end
    tick();
    idle_inputs();
  endtask

  task automatic test_data_miss();
    do_reset();
    mm_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; vectors++;
      if (obs !== MISS) begin $display("FAIL dmiss_cycle%0d got=%b want=%b", i, obs, MISS); miscompares++; end
      tick();
    end
    dhit = 1'b1;
    #1; vectors++;
    if (obs !== ALL_RUN) begin $display("FAIL dmiss_dhit got=%b want=%b", obs, ALL_RUN); miscompares++; end
    tick();
    mm_dREN = 1'b0; mm_dWEN = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
    #1; vectors++;
    if (obs !== MISS) begin $display("FAIL miss_over_branch got=%b want=%b", obs, MISS); miscompares++; end
    tick();
    dhit = 1'b1;
    #1; vectors++;
    if (obs !== BRANCH) begin $display("FAIL deferred_branch got=%b want=%b", obs, BRANCH); miscompares++; end
    tick();
    idle_inputs();
    mm_dREN = 1'b1; dhit = 1'b0;
    tick();
    dhit = 1'b1; wb_halt = 1'b1;
    #1; vectors++;
    if (obs !== FROZEN) begin $display("FAIL dhit_wb_halt got=%b want=%b", obs, FROZEN); miscompares++; end
    tick();
    idle_inputs();
    #1; vectors++;
    if (obs !== FROZEN) begin $display("FAIL dhit_wb_halt_drain got=%b want=%b", obs, FROZEN); miscompares++; end
    tick();
    #1; vectors++;
    if (obs !== FLUSHING) begin $display("FAIL dhit_wb_halt_dflush got=%b want=%b", obs, FLUSHING); miscompares++; end
  endtask

  task automatic test_branch_fetch_miss();
    do_reset();
    ex_branch_taken = 1'b1; ihit = 1'b0;
    #1; vectors++;
    if (obs !== BRANCH) begin $display("FAIL branch_fetch_miss got=%b want=%b", obs, BRANCH); miscompares++; end
    tick();
    ex_branch_taken = 1'b0;
    #1; vectors++;
    if (obs !== FETCH) begin $display("FAIL fetch_miss got=%b want=%b", obs, FETCH); miscompares++; end
    tick();
    idle_inputs();
  endtask

  task automatic test_halt_sequence();
    do_reset();
    mm_halt = 1'b1;
    #1; vectors++;
    if (obs !== HALT_MEM) begin $display("FAIL halt_in_mem got=%b want=%b", obs, HALT_MEM); miscompares++; end
    tick();
    mm_halt = 1'b0; wb_halt = 1'b1;
    #1; vectors++;
    if (obs !== FROZEN) begin $display("FAIL wb_halt got=%b want=%b", obs, FROZEN); miscompares++; end
    tick();
    wb_halt = 1'b0;
    #1; vectors++;
    if (obs !== FROZEN) begin $display("FAIL drain got=%b want=%b", obs, FROZEN); miscompares++; end
    tick();
    for (int i = 0; i < 4; i++) begin
      dflush_done = (i == 3);
      #1; vectors++;
      if (obs !== FLUSHING) begin $display("FAIL dflush_cycle%0d got=%b want=%b", i, obs, FLUSHING); miscompares++; end
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      ihit = $urandom_range(0, 1); mm_dREN = $urandom_range(0, 1); dhit = $urandom_range(0, 1);
      mm_halt = $urandom_range(0, 1); wb_halt = $urandom_range(0, 1);
      ex_branch_taken = $urandom_range(0, 1); dflush_done = $urandom_range(0, 1);
      #1; vectors++;
      if (obs !== HALTED_O) begin $display("FAIL halted_cycle%0d got=%b want=%b", i, obs, HALTED_O); miscompares++; end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_dflush();
    do_reset();
    wb_halt = 1'b1; tick();
    wb_halt = 1'b0; tick();
    #1; vectors++;
    if (obs !== FLUSHING) begin $display("FAIL enter_dflush got=%b want=%b", obs, FLUSHING); miscompares++; end
    nRST = 1'b0;
    #1; vectors++;
    if (obs !== 11'b11111_0000_10) begin
      $display("FAIL reset_comb_in_dflush got=%b want=%b", obs, 11'b11111_0000_10); miscompares++;
    end
    tick();
    #1; vectors++;
    if (obs !== ALL_RUN) begin $display("FAIL reset_drops_dflush got=%b want=%b", obs, ALL_RUN); miscompares++; end
    nRST = 1'b1; ihit = 1'b0;
    #1; vectors++;
    if (obs !== FETCH) begin $display("FAIL run_after_reset got=%b want=%b", obs, FETCH); miscompares++; end
    tick();
    idle_inputs();
  endtask

`ifdef PIPELINE_PERF_EN
  task automatic test_perf_counters();
    do_reset();
    mm_dREN = 1'b1; dhit = 1'b0;
    repeat (3) tick();
    dhit = 1'b1; tick();
    mm_dREN = 1'b0; ex_MemRead = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; tick();
    idle_inputs(); tick();
    #1; vectors++;
    if (stall_cycles !== 32'd4) begin $display("FAIL perf_stall got=%0d want=4", stall_cycles); miscompares++; end
    vectors++;
    if (flush_events !== 32'd4) begin $display("FAIL perf_flush got=%0d want=4", flush_events); miscompares++; end
  endtask
`endif

  task automatic test_random();
    logic [10:0] e;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      nRST            = ($urandom_range(0, 49) != 0);
      ihit            = ($urandom_range(0, 3) != 0);
      dhit            = ($urandom_range(0, 2) != 0);
      mm_dREN         = ($urandom_range(0, 3) == 0);
      mm_dWEN         = ($urandom_range(0, 7) == 0);
      mm_halt         = ($urandom_range(0, 15) == 0);
      wb_halt         = ($urandom_range(0, 23) == 0);
      ex_MemRead      = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      dflush_done     = ($urandom_range(0, 3) == 0);
      ex_rd           = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      #1;
      e = model_out();
      vectors++;
      if (obs !== e) begin $display("FAIL random_cycle%0d got=%b want=%b", n, obs, e); miscompares++; end
`ifdef PIPELINE_PERF_EN
      vectors++;
      if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin
        $display("FAIL random_counters%0d got=%0d/%0d want=%0d/%0d", n, stall_cycles, flush_events,
                 exp_stall, exp_flush);
        miscompares++;
      end
`endif
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_load_use();
    test_data_miss();
    test_branch_fetch_miss();
    test_halt_sequence();
    test_reset_mid_dflush();
`ifdef PIPELINE_PERF_EN
    test_perf_counters();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
